// File: rtl/hfc_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
package hfc_pkg;

    // Widest register address the slot record can carry; narrower
    // addresses are zero-extended on entry.
    localparam int DST_W_MAX = 8;

    // Select value meaning "take the register-file operand".
    localparam int SEL_RF = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [DST_W_MAX-1:0] dst;
        logic                 is_load;
    } slot_t;

    // Width of a forward select able to name slots 1..depth-1 plus SEL_RF.
    function automatic int sel_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hfc_match.sv
// Youngest-first producer search for one source operand over the
// forwardable slots (0..DEPTH-2).
module hfc_match
    import hfc_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int DEPTH    = 3,
    parameter  int ZERO_REG = 1,
    localparam int SEL_W    = sel_width(DEPTH)
) (
    input  slot_t             slots [DEPTH],
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    output logic              hit,
    output logic [SEL_W-1:0]  idx,
    output logic              is_load
);

    logic [DST_W_MAX-1:0] src_ext;
    logic                 src_blocked;

    assign src_ext     = DST_W_MAX'(src);
    assign src_blocked = (ZERO_REG != 0) && (src == '0);

    // Scan oldest to youngest so the youngest matching slot is the last to win.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves
        // a combinational output unassigned would infer a latch.
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (used && !src_blocked && slots[j].valid && slots[j].wr &&
                slots[j].dst == src_ext) begin
                hit     = 1'b1;
                idx     = SEL_W'(j);
                is_load = slots[j].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and operand-forward control. Tracks in-flight destinations
// in a DEPTH-slot shift register (slot 0 = EX, slot DEPTH-1 = WB) and emits
// per-source forward selects registered into EX.
module hazard_forward_ctrl
    import hfc_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int ZERO_REG = 1,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = sel_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_dst,
    input  logic                       id_wr,
    input  logic                       id_is_load,
    input  logic                       flush,
    input  logic                       pipe_hold,
    output logic                       stall_out,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt
);

    slot_t                     slots_q [DEPTH];
    slot_t                     slots_d [DEPTH];
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]        hit;
    logic [NUM_SRC-1:0]        hit_load;
    logic [SEL_W-1:0]          idx [NUM_SRC];
    logic [NUM_SRC-1:0]        load_use;
    logic [NUM_SRC*SEL_W-1:0]  sel_now;
    logic                      inject;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hfc_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .slots   (slots_q),
            .src     (id_src[i*REG_AW +: REG_AW]),
            .used    (id_src_used[i]),
            .hit     (hit[i]),
            .idx     (idx[i]),
            .is_load (hit_load[i])
        );
    end

    // Per-source load-use detection and the select each source would get.
    always_comb begin
        load_use = '0;
        sel_now  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            load_use[i] = hit[i] && hit_load[i] && (int'(idx[i]) < LOAD_LAT);
            sel_now[i*SEL_W +: SEL_W] = hit[i] ? idx[i] + SEL_W'(1) : SEL_W'(SEL_RF);
        end
    end

    // A killed instruction never stalls; only a live, unstalled one enters EX.
    assign stall_out = id_valid && !flush && (|load_use);
    assign inject    = id_valid && !flush && !stall_out;

    // Next state: shift slots, load EX slot or a bubble, update select and counter.
    always_comb begin
        slots_d     = slots_q;
        fwd_sel_d   = fwd_sel_q;
        stall_cnt_d = stall_cnt_q;
        if (!pipe_hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slots_d[k] = slots_q[k-1];
            end
            slots_d[0] = '0;
            if (inject) begin
                slots_d[0] = '{valid: 1'b1, wr: id_wr,
                               dst: DST_W_MAX'(id_dst), is_load: id_is_load};
            end
            fwd_sel_d = inject ? sel_now : '0;
            if (stall_out && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot array is reset, not left to settle, because a stale
            // valid bit would fabricate a hazard on the first instruction.
            for (int k = 0; k < DEPTH; k++) begin
                slots_q[k] <= '0;
            end
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            slots_q     <= slots_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
